// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the MIPS datapath.
// It walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// It drives every datapath mux select and strobe, plus the PC write enable.
//
// Ports:
//   cpu_clk, reset       clock (rising edge), asynchronous active-high reset
//   inst[31:0]           instruction from Inst_Mem, captured in FETCH
//   zero                 ALU zero flag (branch resolution lives in the datapath)
//   overflow             ALU overflow flag, examined in WB for add/sub/addi
//   mem_ready            data-memory completion, examined only in MEM
//   pc_we                PC enable, one pulse per retired instruction
//   signOrZero, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg, ALUControl[2:0],
//   PCSrc[1:0]           selects, latched in DECODE and held until next FETCH
//   RegWrite, MemWrite, MemRead, BranchEq, BranchNeq   datapath strobes
//   trap, trap_cause[1:0] sticky halt flag and its cause (01 illegal,
//                        10 overflow, 11 bus error)
//   retired[CNT_W-1:0]   retired-instruction count (wraps)
//   dbg_state[2:0]       current FSM state: 0 FETCH, 1 DECODE, 2 EXEC,
//                        3 MEM, 4 WB, 5 TRAP
//
// Memory handshake: while in MEM the controller holds MemRead (lw) or
// MemWrite (sw) high. The access completes in the first MEM cycle in which
// mem_ready is sampled high. mem_ready is ignored in every other state.
// After MEM_TIMEOUT consecutive MEM cycles without mem_ready, the bus-error
// trap is taken.
module mc_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             cpu_clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic             zero,
   input  logic             overflow,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             signOrZero,
   output logic             regJal,
   output logic             ALUSrc1,
   output logic             ALUSrc2,
   output logic             RegDst,
   output logic             Mem2Reg,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             MemRead,
   output logic             BranchEq,
   output logic             BranchNeq,
   output logic [2:0]       ALUControl,
   output logic [1:0]       PCSrc,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
      S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL
   } kind_t;

   typedef struct packed {
      logic       soz;
      logic       rjal;
      logic       src1;
      logic       src2;
      logic       rdst;
      logic       m2r;
      logic [2:0] aluc;
      logic [1:0] pcsrc;
   } sel_t;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   kind_t            kind_q, kind_d, dec_kind;
   sel_t             sel_q, sel_d, dec_sel;
   logic [5:0]       op_q, op_d, fn_q, fn_d;
   logic             ovf_chk_q, ovf_chk_d, dec_ovf, dec_legal;
   logic [1:0]       cause_q, cause_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // The zero flag and the register/immediate fields are used by the
   // datapath, not by this controller.
   logic unused_inputs;
   assign unused_inputs = ^{zero, inst[25:6]};

   // Instruction decode from the captured opcode/funct.
   always_comb begin
      dec_sel   = '0;
      dec_kind  = K_ALU;
      dec_ovf   = 1'b0;
      dec_legal = 1'b1;
      case (op_q)
         6'h00: begin
            dec_sel.rdst = 1'b1;
            case (fn_q)
               6'h20: begin dec_sel.aluc = 3'b010; dec_ovf = 1'b1; end
               6'h22: begin dec_sel.aluc = 3'b110; dec_ovf = 1'b1; end
               6'h24: dec_sel.aluc = 3'b000;
               6'h25: dec_sel.aluc = 3'b001;
               6'h27: dec_sel.aluc = 3'b100;
               6'h2A: dec_sel.aluc = 3'b111;
               6'h00: begin dec_sel.aluc = 3'b011; dec_sel.src1 = 1'b1; end
               6'h02: begin dec_sel.aluc = 3'b101; dec_sel.src1 = 1'b1; end
               6'h08: begin
                  dec_sel.rdst  = 1'b0;
                  dec_sel.pcsrc = 2'b11;
                  dec_kind      = K_JR;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h23: begin
            dec_sel.src2 = 1'b1; dec_sel.aluc = 3'b010;
            dec_sel.m2r  = 1'b1; dec_kind = K_LW;
         end
         6'h2B: begin dec_sel.src2 = 1'b1; dec_sel.aluc = 3'b010; dec_kind = K_SW; end
         6'h04: begin dec_sel.aluc = 3'b110; dec_kind = K_BEQ; end
         6'h05: begin dec_sel.aluc = 3'b110; dec_kind = K_BNE; end
         6'h02: begin dec_sel.pcsrc = 2'b10; dec_kind = K_J; end
         6'h03: begin dec_sel.pcsrc = 2'b10; dec_sel.rjal = 1'b1; dec_kind = K_JAL; end
         6'h08: begin dec_sel.src2 = 1'b1; dec_sel.aluc = 3'b010; dec_ovf = 1'b1; end
         6'h0C: begin dec_sel.src2 = 1'b1; dec_sel.soz = 1'b1; dec_sel.aluc = 3'b000; end
         6'h0D: begin dec_sel.src2 = 1'b1; dec_sel.soz = 1'b1; dec_sel.aluc = 3'b001; end
         6'h0A: begin dec_sel.src2 = 1'b1; dec_sel.aluc = 3'b111; end
         default: dec_legal = 1'b0;
      endcase
   end

   // Next-state and strobe logic.
   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      sel_d     = sel_q;
      op_d      = op_q;
      fn_d      = fn_q;
      ovf_chk_d = ovf_chk_q;
      cause_d   = cause_q;
      tmo_d     = '0;
      pc_we     = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      BranchEq  = 1'b0;
      BranchNeq = 1'b0;
      case (state_q)
         S_FETCH: begin
            op_d    = inst[31:26];
            fn_d    = inst[5:0];
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (!dec_legal) begin
               state_d = S_TRAP;
               cause_d = 2'b01;
            end else begin
               sel_d     = dec_sel;
               kind_d    = dec_kind;
               ovf_chk_d = dec_ovf;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            case (kind_q)
               K_ALU: state_d = S_WB;
               K_LW, K_SW: state_d = S_MEM;
               K_BEQ: begin BranchEq = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
               K_BNE: begin BranchNeq = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
               K_JAL: begin RegWrite = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
               default: begin pc_we = 1'b1; state_d = S_FETCH; end
            endcase
         end
         S_MEM: begin
            MemRead  = (kind_q == K_LW);
            MemWrite = (kind_q == K_SW);
            if (mem_ready) begin
               if (kind_q == K_LW) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_TRAP;
               cause_d = 2'b11;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WB: begin
            if (ovf_chk_q && overflow) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               RegWrite = 1'b1;
               pc_we    = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_TRAP: ;
         default: state_d = S_FETCH;
      endcase
      // Selects only describe the instruction in flight; drop them between
      // instructions and once halted.
      if (state_d == S_FETCH || state_d == S_TRAP) sel_d = '0;
   end

   always_comb begin
      retired_d = retired_q;
      if (pc_we) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         kind_q    <= K_ALU;
         sel_q     <= '0;
         op_q      <= '0;
         fn_q      <= '0;
         ovf_chk_q <= 1'b0;
         cause_q   <= 2'b00;
         tmo_q     <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         sel_q     <= sel_d;
         op_q      <= op_d;
         fn_q      <= fn_d;
         ovf_chk_q <= ovf_chk_d;
         cause_q   <= cause_d;
         tmo_q     <= tmo_d;
         retired_q <= retired_d;
      end
   end

   assign signOrZero = sel_q.soz;
   assign regJal     = sel_q.rjal;
   assign ALUSrc1    = sel_q.src1;
   assign ALUSrc2    = sel_q.src2;
   assign RegDst     = sel_q.rdst;
   assign Mem2Reg    = sel_q.m2r;
   assign ALUControl = sel_q.aluc;
   assign PCSrc      = sel_q.pcsrc;
   assign trap       = (state_q == S_TRAP);
   assign trap_cause = cause_q;
   assign retired    = retired_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm. A per-instruction timeline is planned from the
// instruction's mnemonic-level attributes (latency, strobe cycles, selects).
// Every cycle the DUT outputs are compared against that timeline.
module tb_mc_ctrl_fsm;

   localparam int TMO = 16;

   logic        cpu_clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] inst = '0;
   logic        zero = 1'b0, overflow = 1'b0, mem_ready = 1'b0;
   logic        pc_we, signOrZero, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg;
   logic        RegWrite, MemWrite, MemRead, BranchEq, BranchNeq, trap;
   logic [2:0]  ALUControl, dbg_state;
   logic [1:0]  PCSrc, trap_cause;
   logic [31:0] retired;

   mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .cpu_clk(cpu_clk), .reset(reset), .inst(inst), .zero(zero),
      .overflow(overflow), .mem_ready(mem_ready), .pc_we(pc_we),
      .signOrZero(signOrZero), .regJal(regJal), .ALUSrc1(ALUSrc1),
      .ALUSrc2(ALUSrc2), .RegDst(RegDst), .Mem2Reg(Mem2Reg),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
      .BranchEq(BranchEq), .BranchNeq(BranchNeq), .ALUControl(ALUControl),
      .PCSrc(PCSrc), .trap(trap), .trap_cause(trap_cause),
      .retired(retired), .dbg_state(dbg_state)
   );

   always #5 cpu_clk = ~cpu_clk;

   // {pc_we, RegWrite, MemWrite, MemRead, BranchEq, BranchNeq,
   //  signOrZero, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg,
   //  ALUControl, PCSrc, trap, trap_cause}
   logic [19:0] dut_vec;
   assign dut_vec = {pc_we, RegWrite, MemWrite, MemRead, BranchEq, BranchNeq,
                     signOrZero, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg,
                     ALUControl, PCSrc, trap, trap_cause};

   // ---------------- model: instruction table ----------------
   localparam logic [3:0] C_ALU = 4'd0, C_LW = 4'd1, C_SW = 4'd2, C_BEQ = 4'd3,
                          C_BNE = 4'd4, C_J = 4'd5, C_JR = 4'd6, C_JAL = 4'd7;

   typedef struct packed {
      logic       rtype;
      logic [5:0] code;   // funct for R-type, opcode otherwise
      logic [3:0] cls;
      logic [5:0] flg;    // soz, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg
      logic [2:0] aluc;
      logic [1:0] pcs;
      logic       ovf;
   } ent_t;

   ent_t tbl[$];

   typedef struct packed {
      logic        rdy;
      logic [19:0] exp;
   } step_t;

   step_t plan_q[$];

   int checks = 0, failures = 0;
   logic [31:0] exp_ret = '0;
   int obs_pcwe_cyc, obs_pcwe_cnt, obs_rw_cnt, obs_mr_cnt, obs_mw_cnt;
   logic [2:0] obs_aluc;
   logic obs_regdst, obs_m2r;

   task automatic add(input logic r, input logic [5:0] code, input logic [3:0] cls,
                      input logic [5:0] flg, input logic [2:0] aluc,
                      input logic [1:0] pcs, input logic ovf);
      tbl.push_back('{r, code, cls, flg, aluc, pcs, ovf});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [19:0] v(input logic [5:0] stb, input logic [10:0] sel,
                                     input logic tr, input logic [1:0] c);
      return {stb, sel, tr, c};
   endfunction

   // Build the expected per-cycle timeline for one instruction.
   // waits: MEM cycles without mem_ready before it arrives (>= TMO: never).
   task automatic plan(input logic [31:0] ins, input int waits, input logic ovf);
      bit found = 0;
      ent_t e = '0;
      logic [10:0] sel;
      logic [5:0] m;
      foreach (tbl[i]) begin
         if (tbl[i].rtype == (ins[31:26] == 6'h00) &&
             tbl[i].code == (tbl[i].rtype ? ins[5:0] : ins[31:26])) begin
            e = tbl[i];
            found = 1;
         end
      end
      sel = {e.flg, e.aluc, e.pcs};
      plan_q.push_back('{1'b1, v(6'b0, 11'b0, 1'b0, 2'b00)});   // FETCH
      plan_q.push_back('{1'b1, v(6'b0, 11'b0, 1'b0, 2'b00)});   // DECODE
      if (!found) begin
         repeat (3) plan_q.push_back('{1'b1, v(6'b0, 11'b0, 1'b1, 2'b01)});
         return;
      end
      case (e.cls)
         C_ALU: begin
            plan_q.push_back('{1'b1, v(6'b0, sel, 1'b0, 2'b00)});
            if (ovf && e.ovf) begin
               plan_q.push_back('{1'b1, v(6'b0, sel, 1'b0, 2'b00)});
               repeat (3) plan_q.push_back('{1'b1, v(6'b0, 11'b0, 1'b1, 2'b10)});
            end else begin
               plan_q.push_back('{1'b1, v(6'b110000, sel, 1'b0, 2'b00)});
            end
         end
         C_LW, C_SW: begin
            m = (e.cls == C_LW) ? 6'b000100 : 6'b001000;
            plan_q.push_back('{1'b1, v(6'b0, sel, 1'b0, 2'b00)});
            if (waits >= TMO) begin
               repeat (TMO) plan_q.push_back('{1'b0, v(m, sel, 1'b0, 2'b00)});
               repeat (3) plan_q.push_back('{1'b0, v(6'b0, 11'b0, 1'b1, 2'b11)});
            end else begin
               repeat (waits) plan_q.push_back('{1'b0, v(m, sel, 1'b0, 2'b00)});
               if (e.cls == C_LW) begin
                  plan_q.push_back('{1'b1, v(m, sel, 1'b0, 2'b00)});
                  plan_q.push_back('{1'b1, v(6'b110000, sel, 1'b0, 2'b00)});
               end else begin
                  plan_q.push_back('{1'b1, v(m | 6'b100000, sel, 1'b0, 2'b00)});
               end
            end
         end
         C_BEQ: plan_q.push_back('{1'b1, v(6'b100010, sel, 1'b0, 2'b00)});
         C_BNE: plan_q.push_back('{1'b1, v(6'b100001, sel, 1'b0, 2'b00)});
         C_JAL: plan_q.push_back('{1'b1, v(6'b110000, sel, 1'b0, 2'b00)});
         default: plan_q.push_back('{1'b1, v(6'b100000, sel, 1'b0, 2'b00)});
      endcase
   endtask

   // Play the planned timeline; compare outputs mid-cycle (after negedge).
   task automatic run_plan(input int limit);
      step_t s;
      int n = 0;
      obs_pcwe_cyc = 0; obs_pcwe_cnt = 0; obs_rw_cnt = 0;
      obs_mr_cnt = 0; obs_mw_cnt = 0; obs_aluc = '0; obs_regdst = 0; obs_m2r = 0;
      while (plan_q.size() > 0 && (limit == 0 || n < limit)) begin
         s = plan_q.pop_front();
         n++;
         mem_ready = s.rdy;
         #1;
         chk($sformatf("outputs inst=%h cyc%0d", inst, n), {12'd0, dut_vec}, {12'd0, s.exp});
         chk($sformatf("retired cyc%0d", n), retired, exp_ret);
         if (pc_we) begin
            obs_pcwe_cnt++;
            if (obs_pcwe_cyc == 0) obs_pcwe_cyc = n;
            obs_aluc = ALUControl; obs_regdst = RegDst; obs_m2r = Mem2Reg;
         end
         if (RegWrite) obs_rw_cnt++;
         if (MemRead) obs_mr_cnt++;
         if (MemWrite) obs_mw_cnt++;
         if (s.exp[19]) exp_ret++;
         @(negedge cpu_clk);
      end
      plan_q.delete();
   endtask

   task automatic do_instr(input logic [31:0] ins, input int waits,
                           input logic ovf, input logic z);
      inst = ins; overflow = ovf; zero = z;
      plan(ins, waits, ovf);
      run_plan(0);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, " outputs"}, {12'd0, dut_vec}, 32'd0);
      chk({tag, " retired"}, retired, 32'd0);
      chk({tag, " state"}, {29'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge cpu_clk);
      reset = 1'b0;
      exp_ret = '0;
   endtask

   initial begin
      // R-type rows: funct code
      add(1, 6'h20, C_ALU, 6'b000010, 3'b010, 2'b00, 1);   // add
      add(1, 6'h22, C_ALU, 6'b000010, 3'b110, 2'b00, 1);   // sub
      add(1, 6'h24, C_ALU, 6'b000010, 3'b000, 2'b00, 0);   // and
      add(1, 6'h25, C_ALU, 6'b000010, 3'b001, 2'b00, 0);   // or
      add(1, 6'h27, C_ALU, 6'b000010, 3'b100, 2'b00, 0);   // nor
      add(1, 6'h2A, C_ALU, 6'b000010, 3'b111, 2'b00, 0);   // slt
      add(1, 6'h00, C_ALU, 6'b001010, 3'b011, 2'b00, 0);   // sll
      add(1, 6'h02, C_ALU, 6'b001010, 3'b101, 2'b00, 0);   // srl
      add(1, 6'h08, C_JR,  6'b000000, 3'b000, 2'b11, 0);   // jr
      // I/J-type rows: opcode
      add(0, 6'h23, C_LW,  6'b000101, 3'b010, 2'b00, 0);   // lw
      add(0, 6'h2B, C_SW,  6'b000100, 3'b010, 2'b00, 0);   // sw
      add(0, 6'h04, C_BEQ, 6'b000000, 3'b110, 2'b00, 0);   // beq
      add(0, 6'h05, C_BNE, 6'b000000, 3'b110, 2'b00, 0);   // bne
      add(0, 6'h02, C_J,   6'b000000, 3'b000, 2'b10, 0);   // j
      add(0, 6'h03, C_JAL, 6'b010000, 3'b000, 2'b10, 0);   // jal
      add(0, 6'h08, C_ALU, 6'b000100, 3'b010, 2'b00, 1);   // addi
      add(0, 6'h0C, C_ALU, 6'b100100, 3'b000, 2'b00, 0);   // andi
      add(0, 6'h0D, C_ALU, 6'b100100, 3'b001, 2'b00, 0);   // ori
      add(0, 6'h0A, C_ALU, 6'b000100, 3'b111, 2'b00, 0);   // slti

      @(negedge cpu_clk);
      do_reset("reset0");

      // add $3,$1,$2
      do_instr(32'h00221820, 0, 1'b0, 1'b0);
      chk("add pc_we cycle", obs_pcwe_cyc, 4);
      chk("add RegWrite count", obs_rw_cnt, 1);
      chk("add ALUControl", {29'd0, obs_aluc}, 32'd2);
      chk("add RegDst", {31'd0, obs_regdst}, 32'd1);
      #1 chk("add retired", retired, 32'd1);

      // lw $5,8($0), ready after 2 wait cycles
      do_instr(32'h8C050008, 2, 1'b0, 1'b0);
      chk("lw MemRead cycles", obs_mr_cnt, 3);
      chk("lw pc_we cycle", obs_pcwe_cyc, 7);
      chk("lw pc_we count", obs_pcwe_cnt, 1);
      chk("lw Mem2Reg", {31'd0, obs_m2r}, 32'd1);

      do_instr(32'h10220004, 0, 1'b0, 1'b1);   // beq
      chk("beq pc_we cycle", obs_pcwe_cyc, 3);
      chk("beq RegWrite count", obs_rw_cnt, 0);
      do_instr(32'h14220004, 0, 1'b0, 1'b1);   // bne
      chk("bne pc_we cycle", obs_pcwe_cyc, 3);
      do_instr(32'h0C000010, 0, 1'b0, 1'b0);   // jal
      chk("jal pc_we cycle", obs_pcwe_cyc, 3);
      chk("jal RegWrite count", obs_rw_cnt, 1);

      do_instr(32'h00221822, 0, 1'b0, 1'b0);   // sub
      do_instr(32'h00021080, 0, 1'b0, 1'b0);   // sll
      do_instr(32'h00021082, 0, 1'b0, 1'b0);   // srl
      do_instr(32'h0022182A, 0, 1'b0, 1'b0);   // slt
      do_instr(32'h00221827, 0, 1'b0, 1'b0);   // nor
      do_instr(32'h00221824, 0, 1'b1, 1'b0);   // and, overflow ignored
      do_instr(32'h302400FF, 0, 1'b1, 1'b0);   // andi, overflow ignored
      do_instr(32'h342400FF, 0, 1'b0, 1'b0);   // ori
      do_instr(32'h2824000A, 0, 1'b0, 1'b0);   // slti
      do_instr(32'h20240005, 0, 1'b0, 1'b0);   // addi
      do_instr(32'hAC050008, 0, 1'b0, 1'b0);   // sw, no wait
      chk("sw pc_we cycle", obs_pcwe_cyc, 4);
      do_instr(32'hAC050008, 3, 1'b0, 1'b0);   // sw, 3 waits
      do_instr(32'h08000010, 0, 1'b0, 1'b0);   // j
      do_instr(32'h03E00008, 0, 1'b0, 1'b0);   // jr $31
      #1 chk("retired after run", retired, 32'd19);

      // illegal opcode 0x3F
      do_instr(32'hFC000000, 0, 1'b0, 1'b0);
      chk("illegal trap", {31'd0, trap}, 32'd1);
      chk("illegal cause", {30'd0, trap_cause}, 32'd1);
      chk("illegal pc_we count", obs_pcwe_cnt, 0);
      do_reset("reset1");

      // illegal R-type funct
      do_instr(32'h00221801, 0, 1'b0, 1'b0);
      chk("bad funct cause", {30'd0, trap_cause}, 32'd1);
      do_reset("reset2");

      // addi overflow
      do_instr(32'h20240005, 0, 1'b1, 1'b0);
      chk("addi ovf cause", {30'd0, trap_cause}, 32'd2);
      chk("addi ovf RegWrite count", obs_rw_cnt, 0);
      do_reset("reset3");

      // sw never ready -> bus error
      do_instr(32'hAC050008, TMO, 1'b0, 1'b0);
      chk("sw timeout cause", {30'd0, trap_cause}, 32'd3);
      chk("sw timeout MemWrite cycles", obs_mw_cnt, TMO);
      chk("sw timeout pc_we count", obs_pcwe_cnt, 0);
      do_reset("reset4");

      // one instruction to raise retired, then reset in the middle of lw MEM
      do_instr(32'h00221825, 0, 1'b0, 1'b0);   // or
      inst = 32'h8C050008; overflow = 1'b0;
      plan(32'h8C050008, 10, 1'b0);
      run_plan(5);
      do_reset("reset_mid_lw");
      do_instr(32'h00221820, 0, 1'b0, 1'b0);   // add after recovery
      #1 chk("retired after recovery", retired, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath. It replaces the combinational main decoder and generates every datapath control strobe, plus a PC write enable, from inst/zero/overflow.
- Instructions retire in 3–5+ cycles. It stalls on a data-memory ready handshake and traps on illegal opcodes, arithmetic overflow or memory timeout.
- Sits between Inst_Mem/datapath and the data memory wrapper. The datapath PC register CE is driven by pc_we.

Parameters:
- MEM_TIMEOUT, 16, max cycles waited in MEM for mem_ready before a bus-error trap (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- cpu_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst  in  32  current instruction from Inst_Mem (combinational from PC_Current).
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU overflow flag.
- mem_ready  in  1  data memory access complete (sampled in MEM).
- pc_we  out  1  PC register enable; exactly one cycle per retired instruction.
- signOrZero, regJal, ALUSrc1, ALUSrc2, RegDst, Mem2Reg  out  1 each  datapath mux selects.
- RegWrite, MemWrite, MemRead, BranchEq, BranchNeq  out  1 each  datapath strobes.
- ALUControl  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 sll, 101 srl.
- PCSrc  out  2  00/01 pc+4, 10 jump, 11 jr.
- trap  out  1  sticky; the controller has halted.
- trap_cause  out  2  00 none, 01 illegal, 10 overflow, 11 bus error.
- retired  out  CNT_W  retired-instruction count; wraps at 2^CNT_W.

Behaviour:
- Reset (async): state=FETCH; all outputs 0; IR, timeout counter and retired cleared. Reset mid-instruction aborts it with no RegWrite/MemWrite/pc_we.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - FETCH→DECODE: IR<=inst.
  - DECODE: decode IR[31:26]/IR[5:0]; illegal → TRAP with cause 01, else →EXEC.
  - Selects (ALUSrc*, RegDst, signOrZero, ALUControl, PCSrc, Mem2Reg, regJal) are registered in DECODE and held until the next FETCH.
- Supported instructions:
  - R-type funct: add 20, sub 22, and 24, or 25, nor 27, slt 2A, sll 00, srl 02, jr 08.
  - I/J-type opcodes: lw 23, sw 2B, beq 04, bne 05, j 02, jal 03, addi 08, andi 0C, ori 0D, slti 0A.
  - andi/ori use zero-extend (signOrZero=1); the others sign-extend.
  - sll/srl set ALUSrc1=1 (shamt) and ALUSrc2=0.
- EXEC:
  - R-type/imm ALU ops → WB.
  - lw/sw → MEM.
  - beq/bne: BranchEq/BranchNeq=1 and pc_we=1 this cycle → FETCH.
  - j: PCSrc=10, pc_we=1 → FETCH.
  - jr: PCSrc=11, pc_we=1 → FETCH.
  - jal: PCSrc=10, regJal=1, RegWrite=1, pc_we=1 → FETCH.
- MEM:
  - MemRead (lw) or MemWrite (sw) is held until mem_ready.
  - On mem_ready: lw → WB; sw → pc_we=1 → FETCH.
  - The timeout counter increments each MEM cycle without ready. Reaching MEM_TIMEOUT → TRAP with cause 11; MemWrite drops and no pc_we.
- WB:
  - add/sub/addi with overflow=1 → TRAP with cause 10; RegWrite and pc_we are suppressed.
  - Otherwise RegWrite=1, pc_we=1 → FETCH.
- Strobe rules:
  - RegWrite, pc_we, BranchEq and BranchNeq are single-cycle pulses.
  - MemRead/MemWrite are asserted only in MEM.
- retired increments on every pc_we.
- TRAP: all strobes 0, state held until reset.
- Latency: 4 cycles for R-type/imm/sw (0 wait); 5 for lw; 3 for branch/j/jr/jal; +n per mem_ready wait cycle.

Test Plan:
- Reset then IR=add $3,$1,$2 (0x00221820): pc_we and RegWrite high only in cycle 4, ALUControl=010, RegDst=1; retired=1.
- lw $5,8($0) (0x8C050008) with mem_ready after 2 wait cycles: MemRead high for 3 cycles, RegWrite+Mem2Reg in cycle 7, pc_we once.
- beq with zero=1, then bne with zero=1: BranchEq pulse in cycle 3 for beq; BranchNeq asserted in cycle 3 for bne. Both have pc_we=1 and no RegWrite.
- jal (0x0C000010): cycle 3 has regJal=1, RegWrite=1, PCSrc=10, pc_we=1.
- Opcode 0x3F → trap=1, cause=01 after DECODE, pc_we never asserted. Separately, addi with overflow=1 → cause=10, no RegWrite.
- sw with mem_ready held low: trap cause=11 after 16 MEM cycles. Separately, reset asserted during lw MEM: all outputs 0 immediately, state FETCH, retired=0.
